// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter driving a registered common data bus.
// Define CDB_CONFLICT_CNT_EN to add the saturating conflict_cnt output.
module cdb_arbiter #(
    parameter int NUM_FU    = 4,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 4,
    parameter int FU_INDEX  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_FU-1:0]             req_valid,
    input  logic [NUM_FU*WORD_SIZE-1:0]   req_result,
    input  logic [NUM_FU*RB_INDEX-1:0]    req_rb_index,
    output logic [NUM_FU-1:0]             grant,
    input  logic                          stall,
    input  logic                          flush,
    output logic                          cdb_valid,
    output logic [FU_INDEX-1:0]           cdb_fu,
    output logic [RB_INDEX-1:0]           cdb_rb_index,
    output logic [WORD_SIZE-1:0]          cdb_value
`ifdef CDB_CONFLICT_CNT_EN
    ,
    output logic [15:0]                   conflict_cnt
`endif
);
    localparam int PW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;

    logic [PW-1:0] ptr, win, idx;
    logic          found, go;

    // Descending scan so the requester closest to ptr is written last and wins.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = NUM_FU - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NUM_FU);
            if (req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign go    = found & ~stall & ~flush & reset;
    assign grant = go ? NUM_FU'(1) << win : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr          <= '0;
            cdb_valid    <= 1'b0;
            cdb_fu       <= '0;
            cdb_rb_index <= '0;
            cdb_value    <= '0;
        end else begin
            cdb_valid <= go;
            cdb_fu    <= go ? FU_INDEX'(win) + FU_INDEX'(1) : '0;
            if (go) begin
                cdb_rb_index <= req_rb_index[int'(win)*RB_INDEX +: RB_INDEX];
                cdb_value    <= req_result[int'(win)*WORD_SIZE +: WORD_SIZE];
                ptr          <= (win == PW'(NUM_FU - 1)) ? '0 : win + PW'(1);
            end
        end
    end

`ifdef CDB_CONFLICT_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            conflict_cnt <= '0;
        else if ($countones(req_valid) >= 2 && !stall && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and random stimulus checked against a round-robin
// reference model every cycle, plus literal expectations for the test plan.
module tb_cdb_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int R = 4;
    localparam int F = 3;

    logic            clk, reset, stall, flush;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_result;
    logic [N*R-1:0]  req_rb_index;
    logic [N-1:0]    grant;
    logic            cdb_valid;
    logic [F-1:0]    cdb_fu;
    logic [R-1:0]    cdb_rb_index;
    logic [W-1:0]    cdb_value;
`ifdef CDB_CONFLICT_CNT_EN
    logic [15:0]     conflict_cnt;
`endif

    cdb_arbiter #(.NUM_FU(N), .WORD_SIZE(W), .RB_INDEX(R), .FU_INDEX(F)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_result(req_result),
        .req_rb_index(req_rb_index), .grant(grant), .stall(stall), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_fu(cdb_fu), .cdb_rb_index(cdb_rb_index),
        .cdb_value(cdb_value)
`ifdef CDB_CONFLICT_CNT_EN
        , .conflict_cnt(conflict_cnt)
`endif
    );

    int compared = 0;
    int mismatched = 0;
    bit check_en = 0;

    int          m_ptr = 0;
    logic        m_valid = 0;
    logic [F-1:0] m_fu = 0;
    logic [R-1:0] m_rb = 0;
    logic [W-1:0] m_val = 0;
    int          m_cnt = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int winner(input logic [N-1:0] req, input int p);
        for (int off = 0; off < N; off++)
            if (req[(p + off) % N]) return (p + off) % N;
        return -1;
    endfunction

    function automatic int ones(input logic [N-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ptr = 0; m_valid = 0; m_fu = 0; m_rb = 0; m_val = 0; m_cnt = 0;
        end else begin
            int w;
            w = winner(req_valid, m_ptr);
            if (ones(req_valid) >= 2 && !stall && m_cnt < 65535) m_cnt++;
            if (w >= 0 && !stall && !flush) begin
                m_valid = 1;
                m_fu    = F'(w + 1);
                m_rb    = req_rb_index[w*R +: R];
                m_val   = req_result[w*W +: W];
                m_ptr   = (w + 1) % N;
            end else begin
                m_valid = 0;
                m_fu    = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            int w;
            logic [N-1:0] eg;
            w  = winner(req_valid, m_ptr);
            eg = (reset && w >= 0 && !stall && !flush) ? N'(1) << w : '0;
            chk("model grant", 32'(grant), 32'(eg));
            chk("model cdb_valid", 32'(cdb_valid), 32'(m_valid));
            chk("model cdb_fu", 32'(cdb_fu), 32'(m_fu));
            chk("model cdb_rb_index", 32'(cdb_rb_index), 32'(m_rb));
            chk("model cdb_value", cdb_value, m_val);
`ifdef CDB_CONFLICT_CNT_EN
            chk("model conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    logic [N-1:0] eg_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [F-1:0] ef_seq [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};

    initial begin
        reset = 0; stall = 0; flush = 0; req_valid = 0;
        req_result = '0; req_rb_index = '0;
        #12;
        reset = 1;
        check_en = 1;

        // idle after reset
        for (int c = 0; c < 5; c++) begin
            mid();
            chk("idle grant", 32'(grant), 32'h0);
            chk("idle cdb_valid", 32'(cdb_valid), 32'h0);
            chk("idle cdb_fu", 32'(cdb_fu), 32'h0);
        end

        // single request from FU2
        step();
        req_valid = 4'b0100;
        req_result[2*W +: W] = 32'hDEADBEEF;
        req_rb_index[2*R +: R] = 4'h5;
        mid();
        chk("single grant", 32'(grant), 32'h4);
        step();
        req_valid = 4'b0000;
        mid();
        chk("single cdb_valid", 32'(cdb_valid), 32'h1);
        chk("single cdb_fu", 32'(cdb_fu), 32'h3);
        chk("single cdb_rb", 32'(cdb_rb_index), 32'h5);
        chk("single cdb_value", cdb_value, 32'hDEADBEEF);

        // ptr is now 3, so FU3 beats FU0
        step();
        req_valid = 4'b1001;
        mid();
        chk("ptr3 grant", 32'(grant), 32'h8);

        // all four requesting from ptr=0
        for (int i = 0; i < N; i++) begin
            req_result[i*W +: W] = 32'hA000_0000 + 32'(i);
            req_rb_index[i*R +: R] = R'(i + 8);
        end
        step();
        req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            mid();
            if (c < 5) chk("rr grant", 32'(grant), 32'(eg_seq[c]));
            if (c > 0) chk("rr cdb_fu", 32'(cdb_fu), 32'(ef_seq[c-1]));
            if (c < 5) step();
        end

        // stall with all requesting; ptr=1
        stall = 1;
        mid();
        chk("stall grant0", 32'(grant), 32'h0);
        for (int c = 0; c < 2; c++) begin
            step();
            mid();
            chk("stall grant", 32'(grant), 32'h0);
            chk("stall cdb_valid", 32'(cdb_valid), 32'h0);
        end
        step();
        stall = 0;
        mid();
        chk("post-stall grant", 32'(grant), 32'h2);

        // flush kills FU3 the cycle after FU1's grant
        step();
        req_valid = 4'b1000;
        flush = 1;
        mid();
        chk("flush cdb_valid", 32'(cdb_valid), 32'h1);
        chk("flush cdb_fu", 32'(cdb_fu), 32'h2);
        chk("flush grant", 32'(grant), 32'h0);
        step();
        flush = 0;
        req_valid = 4'b0000;
        mid();
        chk("post-flush cdb_valid", 32'(cdb_valid), 32'h0);

        // async reset while broadcasting
        step();
        req_valid = 4'b0001;
        step();
        req_valid = 4'b1111;
        chk("pre-reset cdb_valid", 32'(cdb_valid), 32'h1);
        reset = 0;
        #1;
        chk("async cdb_valid", 32'(cdb_valid), 32'h0);
        chk("async cdb_fu", 32'(cdb_fu), 32'h0);
        chk("async cdb_value", cdb_value, 32'h0);
        chk("async grant", 32'(grant), 32'h0);
        step();
        reset = 1;
        mid();
        chk("post-reset grant", 32'(grant), 32'h1);

        // random traffic checked only by the model
        for (int c = 0; c < 60; c++) begin
            step();
            req_valid    = N'($urandom);
            stall        = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 7) == 0);
            req_result   = {$urandom, $urandom, $urandom, $urandom};
            req_rb_index = 16'($urandom);
        end
        step();
        req_valid = 0; stall = 0; flush = 0;
        mid();
        check_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
